// File: rtl/frame_arb_pkg.sv
// Shared types and widths for the frame-atomic stream arbiter.
package frame_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/frame_stream_arbiter_if.sv
// Per-source image streams in, one arbitrated image stream out.
interface frame_stream_arbiter_if #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned PIX_WID = 24
);
    logic [NUM_SRC-1:0]         s_valid;
    logic [NUM_SRC-1:0]         s_ready;
    logic [NUM_SRC*PIX_WID-1:0] s_data;
    logic [NUM_SRC-1:0]         s_line_last;
    logic [NUM_SRC-1:0]         s_last;
    logic [NUM_SRC-1:0]         s_start;

    logic                       m_valid;
    logic                       m_ready;
    logic [PIX_WID-1:0]         m_data;
    logic                       m_start;
    logic                       m_line_last;
    logic                       m_last;

    // Arbiter side: consumes the sources, drives the merged stream.
    modport master (
        input  s_valid, s_data, s_line_last, s_last, s_start, m_ready,
        output s_ready, m_valid, m_data, m_start, m_line_last, m_last
    );

    // Environment side: drives the sources, consumes the merged stream.
    modport slave (
        output s_valid, s_data, s_line_last, s_last, s_start, m_ready,
        input  s_ready, m_valid, m_data, m_start, m_line_last, m_last
    );
endinterface

// File: rtl/rr_select.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_select #(
    parameter  int unsigned NUM_SRC = 2,
    localparam int unsigned SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] pick,
    output logic [SRC_W-1:0]   idx
);

    logic [SRC_W:0] cand;
    logic           found;

    // Walk the sources in priority order starting at ptr; first hit wins.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand = {1'b0, ptr} + (SRC_W+1)'(k);
            if (cand >= (SRC_W+1)'(NUM_SRC)) begin
                cand = cand - (SRC_W+1)'(NUM_SRC);
            end
            if (!found && req[cand[SRC_W-1:0]]) begin
                found                 = 1'b1;
                pick[cand[SRC_W-1:0]] = 1'b1;
                idx                   = cand[SRC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/frame_stream_arbiter.sv
// Frame-atomic round-robin arbiter: one source owns the output for a whole frame.
module frame_stream_arbiter
    import frame_arb_pkg::*;
#(
    parameter  int unsigned NUM_SRC = 2,
    parameter  int unsigned PIX_WID = 24,
    parameter  int unsigned HEIGHT  = 1080,
    localparam int unsigned SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arb_en,
    frame_stream_arbiter_if.master bus,
    output logic                   busy,
    output logic [SRC_W-1:0]       grant_id,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   err_height
);

    localparam int unsigned LINE_W = $clog2(HEIGHT) + 1;

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   rr_ptr_q;
    logic [SRC_W-1:0]   next_ptr;
    logic [SRC_W-1:0]   pick_idx;
    logic [NUM_SRC-1:0] pick_onehot;
    logic [LINE_W-1:0]  line_cnt_q;

    logic               sel_valid;
    logic               sel_start;
    logic               sel_line_last;
    logic               sel_last;
    logic [PIX_WID-1:0] sel_data;

    logic               pix_hs;
    logic               last_hs;
    logic               line_inc;
    logic               height_bad;
    logic               grant_take;

    rr_select #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_select (
        .req  (bus.s_valid),
        .ptr  (rr_ptr_q),
        .pick (pick_onehot),
        .idx  (pick_idx)
    );

    // Select the granted source's stream; grant_id is held after release.
    always_comb begin
        sel_valid     = 1'b0;
        sel_start     = 1'b0;
        sel_line_last = 1'b0;
        sel_last      = 1'b0;
        sel_data      = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant_id == SRC_W'(i)) begin
                sel_valid     = bus.s_valid[i];
                sel_start     = bus.s_start[i];
                sel_line_last = bus.s_line_last[i];
                sel_last      = bus.s_last[i];
                sel_data      = bus.s_data[i*PIX_WID +: PIX_WID];
            end
        end
    end

    assign pix_hs     = (state_q == GRANT) && sel_valid && bus.m_ready;
    assign last_hs    = pix_hs && sel_last;
    assign line_inc   = pix_hs && sel_line_last && !sel_last && (line_cnt_q != '1);
    assign height_bad = (({1'b0, line_cnt_q}) + (LINE_W+1)'(1)) != (LINE_W+1)'(HEIGHT);
    assign next_ptr   = (pick_idx == SRC_W'(NUM_SRC - 1)) ? '0 : pick_idx + SRC_W'(1);

    // Next-state and stream steering; IDLE forwards nothing.
    always_comb begin
        state_d         = state_q;
        grant_take      = 1'b0;
        bus.m_valid     = 1'b0;
        bus.m_data      = '0;
        bus.m_start     = 1'b0;
        bus.m_line_last = 1'b0;
        bus.m_last      = 1'b0;
        bus.s_ready     = '0;
        frame_done      = 1'b0;
        err_height      = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_en && (|pick_onehot)) begin
                    state_d    = GRANT;
                    grant_take = 1'b1;
                end
            end
            GRANT: begin
                bus.m_valid     = sel_valid;
                bus.m_data      = sel_data;
                bus.m_start     = sel_start;
                bus.m_line_last = sel_line_last;
                bus.m_last      = sel_last;
                for (int unsigned i = 0; i < NUM_SRC; i++) begin
                    if (grant_id == SRC_W'(i)) begin
                        bus.s_ready[i] = bus.m_ready;
                    end
                end
                if (last_hs) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                    err_height = height_bad;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; busy mirrors the registered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == GRANT);
        end
    end

    // Capture the winner and advance the round-robin pointer past it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id <= '0;
            rr_ptr_q <= '0;
        end else if (grant_take) begin
            grant_id <= pick_idx;
            rr_ptr_q <= next_ptr;
        end
    end

    // Count completed lines of the current frame, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt_q <= '0;
        end else if (grant_take) begin
            line_cnt_q <= '0;
        end else if (line_inc) begin
            line_cnt_q <= line_cnt_q + LINE_W'(1);
        end
    end

    // Count forwarded frames, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (last_hs) begin
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end
    end

endmodule

// File: doc/frame_stream_arbiter.md
# frame_stream_arbiter

Frame-atomic round-robin arbiter that shares one downstream pixel pipeline between NUM_SRC upstream image streams (image_generator-style valid/ready sources carrying start/line_last/last markers). A source holds the grant for exactly one whole frame; the grant is released only on the handshaked last pixel. The block also counts forwarded frames and flags frames whose line count differs from HEIGHT.

## Interface
- NUM_SRC, 2: number of sources, 2..4
- PIX_WID, 24: pixel width
- HEIGHT, 1080: expected lines per frame, used for the error check
- SRC_W, $clog2(NUM_SRC): grant index width, derived, not overridable

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- arb_en  in  1  permit new grants; does not abort a frame in progress
- s_valid  in  NUM_SRC  per-source valid
- s_ready  out  NUM_SRC  per-source ready
- s_data  in  NUM_SRC*PIX_WID  per-source pixel, source i at [i*PIX_WID +: PIX_WID]
- s_line_last  in  NUM_SRC  per-source end-of-line, handshake-qualified by the source
- s_last  in  NUM_SRC  per-source end-of-frame, handshake-qualified by the source
- s_start  in  NUM_SRC  per-source first pixel, handshake-qualified by the source
- m_valid  out  1  output valid
- m_ready  in  1  downstream ready
- m_data  out  PIX_WID  output pixel
- m_start, m_line_last, m_last  out  1 each  granted source's markers, passed through
- busy  out  1  a frame is granted
- grant_id  out  SRC_W  index of the granted source, held after release
- frame_done  out  1  one-cycle pulse on each forwarded last-pixel handshake
- frame_cnt  out  16  forwarded frames, wraps 0xFFFF->0
- err_height  out  1  one-cycle pulse coincident with frame_done when line count != HEIGHT

## Operation
- States: IDLE, GRANT.
- IDLE: if arb_en && |s_valid, select a requester round-robin, starting at rr_ptr, and register grant_id. Go to GRANT. Otherwise stay.
- rr_ptr resets to 0. On every grant, rr_ptr becomes (granted+1) mod NUM_SRC.
- GRANT: m_valid = s_valid[grant_id], m_data/m_start/m_line_last/m_last come from the granted source, and s_ready[grant_id] = m_ready. All other s_ready are 0.
- In IDLE: m_valid, all s_ready and all m_* markers are 0.
- Exit GRANT to IDLE on m_valid && m_ready && s_last[grant_id]. On that same cycle:
  - pulse frame_done;
  - increment frame_cnt;
  - compare line_cnt+1 against HEIGHT and pulse err_height on mismatch.
- line_cnt, width $clog2(HEIGHT)+1, clears on entry to GRANT. It increments on each handshaked s_line_last[grant_id] that is not the last pixel. It saturates at all-ones.
- A source that drops s_valid mid-frame keeps the grant; there is no timeout.
- arb_en deasserted in GRANT: the current frame completes, then the block stays in IDLE.

## Timing
- Reset values: state IDLE, busy 0, grant_id 0, rr_ptr 0, frame_cnt 0, line_cnt 0, and every output strobe/valid/ready is 0.
- Grant latency: a request seen in IDLE at cycle N gives GRANT and pass-through from cycle N+1.
- Data path is combinational pass-through with zero latency and no buffering.
- Every frame end costs exactly one mandatory IDLE bubble cycle, even when requests are pending.
- Simultaneous requests are resolved by rr_ptr order only.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is not counted.
- busy = (state==GRANT), registered.

## Structure
- Package frame_arb_pkg holds:
  - state enum {IDLE, GRANT};
  - FRAME_CNT_W = 16.
- Sub-module rr_select: purely combinational. Inputs are the request vector and rr_ptr; outputs are the one-hot pick and its index. The FSM, counters and muxing live in frame_stream_arbiter.

## Test plan
- NUM_SRC=2, HEIGHT=2, 4x2 frames; only source 1 valid, m_ready=1 -> grant_id=1 from cycle 1, 8 pixels forwarded in order, frame_done pulses once, frame_cnt=1, err_height=0, one IDLE cycle follows.
- Both sources always valid -> grants alternate 0,1,0,1; each frame is 8 pixels with no interleaving; s_ready of the non-granted source stays 0 throughout.
- Random m_ready backpressure at 50% -> data order and markers are identical to the no-backpressure run; the non-granted source's counters do not advance.
- Source 0 sends a 3-line frame with HEIGHT=2 -> err_height pulses on its last pixel, coincident with frame_done.
- arb_en dropped at pixel 3 of a frame -> the frame completes; no new grant while arb_en=0; re-asserting it grants on the next cycle.
- rst_n pulsed at pixel 5 -> all outputs 0 asynchronously, frame_cnt=0, the next grant goes to source 0.
